// File: rtl/branch_resolve.sv
// ============================================================================
// branch_resolve: resolves JAL/JALR/BRANCH into a taken flag and PC-relative
// offset for the program counter, with branch statistics and misalign flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_resolve #(
  parameter int CNT_W = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [31:0]             INSTR,
  input  logic [31:0]             IP,
  input  logic [31:0]             RS1_DATA,
  input  logic [31:0]             RS2_DATA,
  output logic                    b_taken,
  output logic signed [31:0]      up_amt,
  output logic                    busy,
  output logic [CNT_W-1:0]        br_cnt,
  output logic [CNT_W-1:0]        taken_cnt,
  output logic                    misalign_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [6:0]       OP_JAL    = 7'b1101111;
  localparam logic [6:0]       OP_JALR   = 7'b1100111;
  localparam logic [6:0]       OP_BRANCH = 7'b1100011;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t            state, state_n;
  logic              taken_n, busy_n, mis_n;
  logic [31:0]       amt_n;
  logic [CNT_W-1:0]  br_n, tk_n;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [31:0]       imm_b, imm_j, imm_i, jalr_tgt, target;
  logic              is_ctrl, cond, dec_taken;
  logic [31:0]       dec_amt;

  // Decode of the instruction currently at IP; only consumed in IDLE.
  always_comb begin
    opcode   = INSTR[6:0];
    funct3   = INSTR[14:12];
    imm_b    = {{19{INSTR[31]}}, INSTR[31], INSTR[7], INSTR[30:25], INSTR[11:8], 1'b0};
    imm_j    = {{11{INSTR[31]}}, INSTR[31], INSTR[19:12], INSTR[20], INSTR[30:21], 1'b0};
    imm_i    = {{20{INSTR[31]}}, INSTR[31:20]};
    jalr_tgt = (RS1_DATA + imm_i) & ~32'd1;

    unique case (funct3)
      3'b000:  cond = (RS1_DATA == RS2_DATA);
      3'b001:  cond = (RS1_DATA != RS2_DATA);
      3'b100:  cond = ($signed(RS1_DATA) <  $signed(RS2_DATA));
      3'b101:  cond = ($signed(RS1_DATA) >= $signed(RS2_DATA));
      3'b110:  cond = (RS1_DATA <  RS2_DATA);
      3'b111:  cond = (RS1_DATA >= RS2_DATA);
      default: cond = 1'b0;
    endcase

    is_ctrl   = 1'b0;
    dec_taken = 1'b0;
    dec_amt   = 32'd0;
    unique case (opcode)
      OP_JAL: begin
        is_ctrl   = 1'b1;
        dec_taken = 1'b1;
        dec_amt   = imm_j;
      end
      OP_JALR: begin
        is_ctrl   = 1'b1;
        dec_taken = 1'b1;
        dec_amt   = jalr_tgt - IP;
      end
      OP_BRANCH: begin
        is_ctrl   = 1'b1;
        dec_taken = cond;
        dec_amt   = cond ? imm_b : 32'd0;
      end
      default: ;
    endcase

    target = IP + dec_amt;
  end

  always_comb begin
    state_n = state;
    taken_n = b_taken;
    amt_n   = up_amt;
    br_n    = br_cnt;
    tk_n    = taken_cnt;
    mis_n   = misalign_err;

    unique case (state)
      IDLE: begin
        taken_n = 1'b0;
        amt_n   = 32'd0;
        if (is_ctrl) begin
          state_n = RESOLVE;
          taken_n = dec_taken;
          amt_n   = dec_amt;
          br_n    = br_cnt + CNT_ONE;
          if (dec_taken) begin
            tk_n = taken_cnt + CNT_ONE;
            if (target[1:0] != 2'b00) mis_n = 1'b1;
          end
        end
      end
      RESOLVE: begin
        // Not-taken results are already zero, so only the state moves.
        state_n = b_taken ? HOLD : IDLE;
      end
      HOLD: begin
        state_n = IDLE;
        taken_n = 1'b0;
        amt_n   = 32'd0;
      end
      default: begin
        state_n = IDLE;
        taken_n = 1'b0;
        amt_n   = 32'd0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      b_taken      <= 1'b0;
      up_amt       <= 32'sd0;
      busy         <= 1'b0;
      br_cnt       <= '0;
      taken_cnt    <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      b_taken      <= taken_n;
      up_amt       <= amt_n;
      busy         <= busy_n;
      br_cnt       <= br_n;
      taken_cnt    <= tk_n;
      misalign_err <= mis_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed transfers, capture isolation,
// misalign stickiness, reset in HOLD and counter wrap (narrow counters).
`default_nettype none

module tb_branch_resolve;

  localparam int          CW  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic                CLK = 1'b0;
  logic                RESET;
  logic [31:0]         INSTR, IP, RS1_DATA, RS2_DATA;
  logic                b_taken;
  logic signed [31:0]  up_amt;
  logic                busy;
  logic [CW-1:0]       br_cnt, taken_cnt;
  logic                misalign_err;

  typedef struct {
    logic        taken;
    logic [31:0] amt;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_br = '0;
  logic [CW-1:0] exp_tk = '0;

  branch_resolve #(.CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .IP(IP),
    .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
    .b_taken(b_taken), .up_amt(up_amt), .busy(busy),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt), .misalign_err(misalign_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm);
    return {imm[11:0], 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  // Issue one control instruction in IDLE, scramble operands after capture,
  // return one step after IDLE resumes and check the counters there.
  task automatic send(input logic [31:0] instr, input logic [31:0] ip,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic exp_taken, input logic [31:0] exp_amt,
                      input logic keep);
    exp_t e;
    @(negedge CLK);
    INSTR = instr; IP = ip; RS1_DATA = rs1; RS2_DATA = rs2;
    e.taken = exp_taken;
    e.amt   = exp_amt;
    exp_q.push_back(e);
    exp_br = exp_br + 1'b1;
    if (exp_taken) exp_tk = exp_tk + 1'b1;
    @(posedge CLK); #1;
    IP = 32'hDEAD_BEE0; RS1_DATA = 32'h1234_5671; RS2_DATA = 32'h0FED_CBA9;
    if (!keep) INSTR = NOP;
    if (exp_taken) @(posedge CLK);
    @(posedge CLK); #1;
    INSTR = NOP;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("br_cnt", {{(32-CW){1'b0}}, br_cnt}, {{(32-CW){1'b0}}, exp_br});
    chk("taken_cnt", {{(32-CW){1'b0}}, taken_cnt}, {{(32-CW){1'b0}}, exp_tk});
  endtask

  // Monitor: a rising busy marks the RESOLVE cycle; the next cycle is HOLD or IDLE.
  initial begin : monitor
    logic prev;
    exp_t m;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (busy === 1'b1 && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resolve: busy 1 with no pending transfer, expected 0");
        end else begin
          m = exp_q.pop_front();
          chk("resolve_taken", {31'd0, b_taken}, {31'd0, m.taken});
          chk("resolve_amt", up_amt, m.amt);
          @(negedge CLK);
          chk("hold_busy", {31'd0, busy}, {31'd0, m.taken});
          if (m.taken) begin
            chk("hold_taken", {31'd0, b_taken}, 32'd1);
            chk("hold_amt", up_amt, m.amt);
          end
        end
      end
      prev = (busy === 1'b1);
    end
  end

  initial begin : stim
    exp_t r;
    RESET = 1'b1; INSTR = NOP; IP = '0; RS1_DATA = '0; RS2_DATA = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    chk("rst_taken", {31'd0, b_taken}, 32'd0);
    chk("rst_amt", up_amt, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_br", {24'd0, br_cnt}, 32'd0);
    chk("rst_tk", {24'd0, taken_cnt}, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);

    send(enc_b(3'b000, 32'd16), 32'h100, 32'd5, 32'd5, 1'b1, 32'd16, 1'b0);
    send(enc_b(3'b100, 32'hFFFF_FFFC), 32'h200, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    send(enc_b(3'b110, 32'hFFFF_FFFC), 32'h200, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b0);
    send(enc_b(3'b001, 32'd8), 32'h300, 32'd9, 32'd9, 1'b0, 32'd0, 1'b0);
    send(enc_b(3'b001, 32'd8), 32'h300, 32'd9, 32'd4, 1'b1, 32'd8, 1'b0);
    send(enc_b(3'b101, 32'd12), 32'h400, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'd12, 1'b0);
    send(enc_b(3'b111, 32'd12), 32'h400, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
    send(enc_b(3'b010, 32'd12), 32'h400, 32'd7, 32'd7, 1'b0, 32'd0, 1'b0);
    send(enc_j(32'hFFFF_FFF8), 32'h40, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    chk("mis_before", {31'd0, misalign_err}, 32'd0);

    send(enc_i(32'd0), 32'h100, 32'h203, 32'd0, 1'b1, 32'h102, 1'b0);
    chk("mis_set", {31'd0, misalign_err}, 32'd1);
    send(enc_i(32'hFFFF_FFFF), 32'h100, 32'h1001, 32'd0, 1'b1, 32'hF00, 1'b0);
    chk("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // Non-control instructions must never start a resolve.
    @(negedge CLK);
    INSTR = 32'h0020_8033;
    repeat (5) @(negedge CLK);
    INSTR = NOP;
    chk("nonctrl_br", {24'd0, br_cnt}, {24'd0, exp_br});

    // Reset asserted while in HOLD.
    @(negedge CLK);
    INSTR = enc_b(3'b000, 32'd16); IP = 32'h100; RS1_DATA = 32'd7; RS2_DATA = 32'd7;
    r.taken = 1'b1;
    r.amt   = 32'd16;
    exp_q.push_back(r);
    @(posedge CLK); #1 INSTR = NOP;
    @(posedge CLK); #1;
    chk("hold_before_rst", {31'd0, busy}, 32'd1);
    RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    chk("hrst_taken", {31'd0, b_taken}, 32'd0);
    chk("hrst_amt", up_amt, 32'd0);
    chk("hrst_busy", {31'd0, busy}, 32'd0);
    chk("hrst_br", {24'd0, br_cnt}, 32'd0);
    chk("hrst_tk", {24'd0, taken_cnt}, 32'd0);
    chk("hrst_mis", {31'd0, misalign_err}, 32'd0);
    exp_br = '0;
    exp_tk = '0;

    for (int i = 0; i < (1 << CW); i++)
      send(enc_b(3'b001, 32'd8), 32'h300, 32'd9, 32'd9, 1'b0, 32'd0, 1'b0);
    chk("wrap_br", {24'd0, br_cnt}, 32'd0);
    chk("wrap_tk", {24'd0, taken_cnt}, 32'd0);

    repeat (3) @(posedge CLK);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
